// File: rtl/bp_pkg.sv
`default_nettype none
//==============================================================================
// bp_pkg: shared counter encodings, reset value and default sizing (rev 1.0)
//==============================================================================
package bp_pkg;

  localparam int DEFAULT_INDEX_BITS = 6;
  localparam int DEFAULT_HIST_BITS  = 4;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } ctr_e;

  localparam ctr_e CTR_RESET = WNT;

  // One step along SNT <-> WNT <-> WT <-> ST, holding at either end.
  function automatic ctr_e ctr_step(input ctr_e cur, input logic taken);
    case (cur)
      SNT:     return taken ? WNT : SNT;
      WNT:     return taken ? WT  : SNT;
      WT:      return taken ? ST  : WNT;
      default: return taken ? ST  : WT;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/bp_if.sv
`default_nettype none
//==============================================================================
// bp_if: fetch-lookup and EX-resolve signals between pipeline and predictor (rev 1.0)
//==============================================================================
interface bp_if
  import bp_pkg::*;
#(
  parameter int INDEX_BITS = DEFAULT_INDEX_BITS
) ();

  logic                  if_valid;
  logic [63:0]           if_pc;
  logic                  pred_taken;
  logic [INDEX_BITS-1:0] pred_index;
  logic                  ex_branch;
  logic [INDEX_BITS-1:0] ex_index;
  logic                  ex_pred_taken;
  logic                  ex_taken;
  logic                  branchex;
  logic                  BranchFlush;

  modport master (
    output if_valid, if_pc, ex_branch, ex_index, ex_pred_taken, ex_taken,
    input  pred_taken, pred_index, branchex, BranchFlush
  );

  modport slave (
    input  if_valid, if_pc, ex_branch, ex_index, ex_pred_taken, ex_taken,
    output pred_taken, pred_index, branchex, BranchFlush
  );

endinterface
`default_nettype wire

// File: rtl/bp_table.sv
`default_nettype none
//==============================================================================
// bp_table: 2-bit counter array, async read, sync saturating update/reset (rev 1.0)
//==============================================================================
module bp_table
  import bp_pkg::*;
#(
  parameter int INDEX_BITS = DEFAULT_INDEX_BITS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [INDEX_BITS-1:0] rd_index,
  output ctr_e                  rd_ctr,
  input  logic                  upd_en,
  input  logic [INDEX_BITS-1:0] upd_index,
  input  logic                  upd_taken
);

  localparam int c_depth = 1 << INDEX_BITS;

  ctr_e r_ctr [c_depth];

  // Read is purely combinational, so a same-cycle update is never bypassed.
  assign rd_ctr = r_ctr[rd_index];

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < c_depth; i++) begin
        r_ctr[i] <= CTR_RESET;
      end
    end else if (upd_en) begin
      r_ctr[upd_index] <= ctr_step(r_ctr[upd_index], upd_taken);
    end
  end

endmodule
`default_nettype wire

// File: rtl/branch_predictor.sv
`default_nettype none
//==============================================================================
// branch_predictor: gshare direction predictor with non-speculative history (rev 1.0)
//==============================================================================
module branch_predictor
  import bp_pkg::*;
#(
  parameter int INDEX_BITS = DEFAULT_INDEX_BITS,
  parameter int HIST_BITS  = DEFAULT_HIST_BITS
) (
  input logic clk,
  input logic rst,
  bp_if.slave bus
);

  logic [HIST_BITS-1:0]  r_ghr;
  logic [INDEX_BITS-1:0] w_ghr_ext;
  logic [INDEX_BITS-1:0] w_index;
  ctr_e                  w_ctr;
  logic                  w_unused_pc;

  always_comb begin
    w_ghr_ext                 = '0;
    w_ghr_ext[HIST_BITS-1:0]  = r_ghr;
  end

  assign w_index     = bus.if_pc[INDEX_BITS+1:2] ^ w_ghr_ext;
  assign w_unused_pc = ^{bus.if_pc[63:INDEX_BITS+2], bus.if_pc[1:0]};

  assign bus.pred_index  = w_index;
  assign bus.pred_taken  = bus.if_valid & w_ctr[1];
  assign bus.branchex    = bus.ex_branch;
  assign bus.BranchFlush = bus.ex_branch & (bus.ex_taken ^ bus.ex_pred_taken);

  // History only advances on resolved branches; lookups see the old value.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_ghr <= '0;
    end else if (bus.ex_branch) begin
      r_ghr <= {r_ghr[HIST_BITS-2:0], bus.ex_taken};
    end
  end

  bp_table #(
    .INDEX_BITS (INDEX_BITS)
  ) u_table (
    .clk       (clk),
    .rst       (rst),
    .rd_index  (w_index),
    .rd_ctr    (w_ctr),
    .upd_en    (bus.ex_branch),
    .upd_index (bus.ex_index),
    .upd_taken (bus.ex_taken)
  );

endmodule
`default_nettype wire

// File: tb/tb_branch_predictor.sv
`default_nettype none
//==============================================================================
// tb_branch_predictor: scoreboard bench for the gshare predictor (rev 1.0)
//==============================================================================
module tb_branch_predictor;

  localparam int INDEX_BITS = 6;
  localparam int HIST_BITS  = 4;

  typedef struct {
    string      tag;
    logic [8:0] exp;
  } sb_t;

  logic clk;
  logic rst;

  bp_if #(.INDEX_BITS(INDEX_BITS)) bus ();

  branch_predictor #(
    .INDEX_BITS (INDEX_BITS),
    .HIST_BITS  (HIST_BITS)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  sb_t        sb [$];
  logic [1:0] m_ctr [64];
  logic [3:0] m_ghr;

  logic       obs_pt;
  logic [5:0] obs_idx;
  logic       obs_bx;
  logic       obs_fl;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [1:0] m_sat(input logic [1:0] c, input logic tk);
    if (tk) return (c == 2'd3) ? 2'd3 : c + 2'd1;
    else    return (c == 2'd0) ? 2'd0 : c - 2'd1;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 64; i++) m_ctr[i] = 2'b01;
    m_ghr = 4'd0;
  endtask

  function automatic logic [63:0] pc_for(input logic [5:0] idx);
    logic [5:0] raw;
    raw = idx ^ {2'b00, m_ghr};
    return {56'd0, raw, 2'b00};
  endfunction

  // One cycle: drive at negedge, push model expectation, sample, pop and compare.
  task automatic step(input string tag, input logic r, input logic v, input logic [63:0] pc,
                      input logic br, input logic [5:0] idx, input logic ptk, input logic tk);
    logic [5:0] ei;
    sb_t        e;
    @(negedge clk);
    rst               = r;
    bus.if_valid      = v;
    bus.if_pc         = pc;
    bus.ex_branch     = br;
    bus.ex_index      = idx;
    bus.ex_pred_taken = ptk;
    bus.ex_taken      = tk;
    ei = pc[7:2] ^ {2'b00, m_ghr};
    sb.push_back('{tag: tag, exp: {v & m_ctr[ei][1], ei, br, br & (tk ^ ptk)}});
    #2;
    obs_pt  = bus.pred_taken;
    obs_idx = bus.pred_index;
    obs_bx  = bus.branchex;
    obs_fl  = bus.BranchFlush;
    e = sb.pop_front();
    check(e.tag, {55'd0, obs_pt, obs_idx, obs_bx, obs_fl}, {55'd0, e.exp});
    @(posedge clk);
    if (!r) m_reset();
    else if (br) begin
      m_ctr[idx] = m_sat(m_ctr[idx], tk);
      m_ghr      = {m_ghr[2:0], tk};
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    bus.if_valid = 0; bus.if_pc = '0; bus.ex_branch = 0;
    bus.ex_index = '0; bus.ex_pred_taken = 0; bus.ex_taken = 0;
    m_reset();
    repeat (2) @(posedge clk);

    // Reset lookup
    step("r035", 1, 1, 64'h40, 0, 0, 0, 0);
    check("r035_idx", obs_idx, 64'h10);
    check("r035_pt", obs_pt, 0);

    // Two taken mispredicts on 0x10, then four not-taken elsewhere to flush ghr
    for (int k = 0; k < 2; k++) begin
      step("r036_pulse", 1, 0, 64'h0, 1, 6'h10, 0, 1);
      check("r036_flush", obs_fl, 1);
      check("r036_bx", obs_bx, 1);
    end
    for (int k = 0; k < 4; k++) step("r036_nt", 1, 0, 64'h0, 1, 6'h20 + 6'(k), 0, 0);
    step("r036_look", 1, 1, 64'h40, 0, 0, 0, 0);
    check("r036_idx", obs_idx, 64'h10);
    check("r036_st", obs_pt, 1);
    step("r036_dec1", 1, 0, 64'h0, 1, 6'h10, 1, 0);
    check("r036_dec1_fl", obs_fl, 1);
    step("r036_wt", 1, 1, pc_for(6'h10), 0, 0, 0, 0);
    check("r036_wt_pt", obs_pt, 1);
    step("r036_dec2", 1, 0, 64'h0, 1, 6'h10, 1, 0);
    step("r036_wnt", 1, 1, pc_for(6'h10), 0, 0, 0, 0);
    check("r036_wnt_pt", obs_pt, 0);

    // Saturation at ST, then one step down
    step("rst37", 0, 0, 64'h0, 0, 0, 0, 0);
    for (int k = 0; k < 5; k++) step("r037_tk", 1, 0, 64'h0, 1, 6'd3, 1, 1);
    step("r037_sat", 1, 1, pc_for(6'd3), 0, 0, 0, 0);
    check("r037_sat_pt", obs_pt, 1);
    step("r037_nt", 1, 0, 64'h0, 1, 6'd3, 1, 0);
    step("r037_wt", 1, 1, pc_for(6'd3), 0, 0, 0, 0);
    check("r037_wt_pt", obs_pt, 1);
    step("r037_nt2", 1, 0, 64'h0, 1, 6'd3, 1, 0);
    step("r037_wnt", 1, 1, pc_for(6'd3), 0, 0, 0, 0);
    check("r037_wnt_pt", obs_pt, 0);

    // History T,T,NT,T -> 1101
    step("rst38", 0, 0, 64'h0, 0, 0, 0, 0);
    step("r038_t1", 1, 0, 64'h0, 1, 6'd7, 0, 1);
    step("r038_t2", 1, 0, 64'h0, 1, 6'd7, 0, 1);
    step("r038_n3", 1, 0, 64'h0, 1, 6'd7, 0, 0);
    step("r038_t4", 1, 0, 64'h0, 1, 6'd7, 0, 1);
    step("r038_look", 1, 1, 64'h0, 0, 0, 0, 0);
    check("r038_idx", obs_idx, 64'h0D);
    check("r038_pt", obs_pt, 0);

    // Same-cycle lookup and update at index 5
    step("rst39", 0, 0, 64'h0, 0, 0, 0, 0);
    step("r039_same", 1, 1, 64'h14, 1, 6'd5, 0, 1);
    check("r039_same_pt", obs_pt, 0);
    check("r039_same_idx", obs_idx, 64'd5);
    step("r039_next", 1, 1, 64'h10, 0, 0, 0, 0);
    check("r039_next_idx", obs_idx, 64'd5);
    check("r039_next_pt", obs_pt, 1);

    // Reset while an update is presented
    for (int k = 0; k < 3; k++) step("r040_pre", 1, 0, 64'h0, 1, 6'd9, 0, 1);
    step("r040_rst_a", 0, 1, pc_for(6'd9), 1, 6'd9, 0, 1);
    check("r040_rst_fl", obs_fl, 1);
    check("r040_rst_bx", obs_bx, 1);
    step("r040_rst_b", 0, 1, 64'h24, 1, 6'd9, 1, 1);
    check("r040_rst_fl0", obs_fl, 0);
    step("r040_post", 1, 1, 64'h24, 0, 0, 0, 0);
    check("r040_post_idx", obs_idx, 64'd9);
    check("r040_post_pt", obs_pt, 0);
    step("r040_upd", 1, 0, 64'h0, 1, 6'd9, 0, 1);
    step("r040_after", 1, 1, 64'h0, 0, 0, 0, 0);
    check("r040_ghr_idx", obs_idx, 64'h01);
    step("r040_wt", 1, 1, pc_for(6'd9), 0, 0, 0, 0);
    check("r040_wt_pt", obs_pt, 1);

    // No flush without a resolving branch
    step("nobr", 1, 1, 64'h80, 0, 6'd2, 1, 0);
    check("nobr_fl", obs_fl, 0);

    // Random traffic against the model
    for (int k = 0; k < 400; k++) begin
      step("rand", ($urandom_range(49) != 0), 1'($urandom), {$urandom, $urandom},
           1'($urandom), 6'($urandom), 1'($urandom), 1'($urandom));
    end

    check("sb_empty", 64'(sb.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
